// File: rtl/adder_share_arbiter.sv
// Four requesters share one 4-bit adder; round-robin grant, tagged pipelined results.
// Define ADDER_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 highest, no pointer).
module adder_share_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  req,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic        flush,
  output logic [3:0]  gnt,
  output logic [3:0]  res_valid,
  output logic [3:0]  sum_out,
  output logic        c_out,
  output logic        busy
);

  localparam int NS = LATENCY + 1;

  logic [3:0]    gnt_raw;
  logic [1:0]    gnt_idx;
  logic [3:0]    a_sel;
  logic [3:0]    b_sel;
  logic [4:0]    sum_new;
  logic [NS-1:0] vld;
  logic [1:0]    tag [NS];
  logic [4:0]    dat [NS];

`ifdef ADDER_ARB_FIXED_PRIORITY_EN
  always_comb begin
    gnt_raw = '0;
    gnt_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) begin
        gnt_raw = 4'b0001 << k;
        gnt_idx = 2'(k);
      end
    end
  end
`else
  logic [1:0] ptr;
  logic [1:0] idx;
  logic       found;

  // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
  always_comb begin
    gnt_raw = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_raw = 4'b0001 << idx;
        gnt_idx = idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= gnt_idx + 2'd1;
    end
  end
`endif

  // Grants are masked during reset and in a flush cycle.
  assign gnt     = (RST && !flush) ? gnt_raw : 4'b0000;
  assign a_sel   = a_in[{gnt_idx, 2'b00} +: 4];
  assign b_sel   = b_in[{gnt_idx, 2'b00} +: 4];
  assign sum_new = {1'b0, a_sel} + {1'b0, b_sel};

  // Data registers load only alongside a valid, so the last stage holds the last result.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld <= '0;
      for (int k = 0; k < NS; k++) begin
        tag[k] <= '0;
        dat[k] <= '0;
      end
    end else begin
      vld[0] <= |gnt;
      if (|gnt) begin
        tag[0] <= gnt_idx;
        dat[0] <= sum_new;
      end
      for (int k = 1; k < NS; k++) begin
        vld[k] <= vld[k-1] && !flush;
        if (vld[k-1] && !flush) begin
          tag[k] <= tag[k-1];
          dat[k] <= dat[k-1];
        end
      end
    end
  end

  assign res_valid = vld[LATENCY] ? (4'b0001 << tag[LATENCY]) : 4'b0000;
  assign sum_out   = dat[LATENCY][3:0];
  assign c_out     = dat[LATENCY][4];
  assign busy      = |vld;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized and directed bench for adder_share_arbiter against a queue-based model.
module tb_adder_share_arbiter;

  localparam int LAT = 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        flush = 1'b0;
  logic [3:0]  gnt, res_valid, sum_out;
  logic        c_out, busy;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  typedef struct {int due; int tag; int sum;} op_t;
  op_t inflight[$];
  int  last_gnt = 3;
  int  hold_sum = 0;
  int  e_idx;
  logic [3:0] e_gnt, e_rv, e_sum;
  logic       e_c, e_busy;

  adder_share_arbiter #(.LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST), .req(req), .a_in(a_in), .b_in(b_in), .flush(flush),
    .gnt(gnt), .res_valid(res_valid), .sum_out(sum_out), .c_out(c_out), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  function automatic int pick(logic [3:0] r);
`ifdef ADDER_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int off = 1; off <= 4; off++) if (r[(last_gnt + off) % 4]) return (last_gnt + off) % 4;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    inflight.delete();
    last_gnt = 3;
    hold_sum = 0;
  endtask

  task automatic expect_now();
    @(negedge CLK);
    e_idx = flush ? -1 : pick(req);
    e_gnt = (e_idx < 0) ? 4'b0000 : 4'(1 << e_idx);
    e_rv  = 4'b0000;
    if (inflight.size() > 0 && inflight[0].due == cyc) begin
      e_rv     = 4'(1 << inflight[0].tag);
      hold_sum = inflight[0].sum;
    end
    e_sum  = 4'(hold_sum % 16);
    e_c    = (hold_sum >= 16);
    e_busy = (inflight.size() != 0);
  endtask

  task automatic advance();
    int s;
    op_t op;
    if (inflight.size() > 0 && inflight[0].due == cyc) void'(inflight.pop_front());
    if (flush) begin
      inflight.delete();
    end else if (e_idx >= 0) begin
      s = int'(a_in[4*e_idx +: 4]) + int'(b_in[4*e_idx +: 4]);
      op.due = cyc + LAT + 1;
      op.tag = e_idx;
      op.sum = s;
      inflight.push_back(op);
      last_gnt = e_idx;
    end
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    req = 4'hF;
    a_in = 16'(($urandom));
    b_in = 16'(($urandom));
    model_reset();
    @(posedge CLK);
    #1;
    vecs++; if (gnt !== 4'b0000)       begin errs++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    vecs++; if (res_valid !== 4'b0000) begin errs++; $display("FAIL rst_rv got=%b exp=0000", res_valid); end
    vecs++; if (sum_out !== 4'h0)      begin errs++; $display("FAIL rst_sum got=%h exp=0", sum_out); end
    vecs++; if (c_out !== 1'b0)        begin errs++; $display("FAIL rst_c got=%b exp=0", c_out); end
    vecs++; if (busy !== 1'b0)         begin errs++; $display("FAIL rst_busy got=%b exp=0", busy); end
    RST = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      req  = (i == 0) ? 4'b0001 : 4'b0000;
      a_in = 16'h0003;
      b_in = 16'h0004;
      expect_now();
      vecs++; if (gnt !== e_gnt)         begin errs++; $display("FAIL basic_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      vecs++; if (res_valid !== e_rv)    begin errs++; $display("FAIL basic_rv cyc=%0d got=%b exp=%b", cyc, res_valid, e_rv); end
      vecs++; if (sum_out !== e_sum)     begin errs++; $display("FAIL basic_sum cyc=%0d got=%h exp=%h", cyc, sum_out, e_sum); end
      vecs++; if (c_out !== e_c)         begin errs++; $display("FAIL basic_c cyc=%0d got=%b exp=%b", cyc, c_out, e_c); end
      vecs++; if (busy !== e_busy)       begin errs++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      if (i == 0) begin
        vecs++; if (gnt !== 4'b0001) begin errs++; $display("FAIL basic_first_gnt got=%b exp=0001", gnt); end
      end
      if (i == 2) begin
        vecs++; if (res_valid !== 4'b0001 || sum_out !== 4'd7 || c_out !== 1'b0)
          begin errs++; $display("FAIL basic_result got=%b/%h/%b exp=0001/7/0", res_valid, sum_out, c_out); end
      end
      advance();
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      req  = (i == 0) ? 4'b0100 : 4'b0000;
      a_in = 16'h0F00;
      b_in = 16'h0100;
      expect_now();
      vecs++; if (gnt !== e_gnt)         begin errs++; $display("FAIL ovf_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      vecs++; if (res_valid !== e_rv)    begin errs++; $display("FAIL ovf_rv cyc=%0d got=%b exp=%b", cyc, res_valid, e_rv); end
      vecs++; if (sum_out !== e_sum)     begin errs++; $display("FAIL ovf_sum cyc=%0d got=%h exp=%h", cyc, sum_out, e_sum); end
      vecs++; if (c_out !== e_c)         begin errs++; $display("FAIL ovf_c cyc=%0d got=%b exp=%b", cyc, c_out, e_c); end
      vecs++; if (busy !== e_busy)       begin errs++; $display("FAIL ovf_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      if (i == 2) begin
        vecs++; if (res_valid !== 4'b0100 || sum_out !== 4'd0 || c_out !== 1'b1)
          begin errs++; $display("FAIL ovf_result got=%b/%h/%b exp=0100/0/1", res_valid, sum_out, c_out); end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      req  = (i < 5) ? 4'b1111 : 4'b0000;
      a_in = 16'(($urandom));
      b_in = 16'(($urandom));
      expect_now();
      vecs++; if (gnt !== e_gnt)         begin errs++; $display("FAIL b2b_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      vecs++; if (res_valid !== e_rv)    begin errs++; $display("FAIL b2b_rv cyc=%0d got=%b exp=%b", cyc, res_valid, e_rv); end
      vecs++; if (sum_out !== e_sum)     begin errs++; $display("FAIL b2b_sum cyc=%0d got=%h exp=%h", cyc, sum_out, e_sum); end
      vecs++; if (c_out !== e_c)         begin errs++; $display("FAIL b2b_c cyc=%0d got=%b exp=%b", cyc, c_out, e_c); end
      vecs++; if (busy !== e_busy)       begin errs++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      advance();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      req   = (i < 2) ? ((i == 0) ? 4'b0010 : 4'b1111) : 4'b0000;
      flush = (i == 1);
      a_in  = 16'(($urandom));
      b_in  = 16'(($urandom));
      expect_now();
      vecs++; if (gnt !== e_gnt)         begin errs++; $display("FAIL flush_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      vecs++; if (res_valid !== e_rv)    begin errs++; $display("FAIL flush_rv cyc=%0d got=%b exp=%b", cyc, res_valid, e_rv); end
      vecs++; if (sum_out !== e_sum)     begin errs++; $display("FAIL flush_sum cyc=%0d got=%h exp=%h", cyc, sum_out, e_sum); end
      vecs++; if (c_out !== e_c)         begin errs++; $display("FAIL flush_c cyc=%0d got=%b exp=%b", cyc, c_out, e_c); end
      vecs++; if (busy !== e_busy)       begin errs++; $display("FAIL flush_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      if (i >= 2) begin
        vecs++; if (busy !== 1'b0 || res_valid !== 4'b0000)
          begin errs++; $display("FAIL flush_drained cyc=%0d got=%b/%b exp=0/0000", cyc, busy, res_valid); end
      end
      advance();
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    req  = 4'b1111;
    a_in = 16'(($urandom));
    b_in = 16'(($urandom));
    expect_now();
    vecs++; if (gnt !== e_gnt) begin errs++; $display("FAIL rmid_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
    advance();
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
    #2;
    RST = 1'b0;
    model_reset();
    #1;
    vecs++; if (gnt !== 4'b0000 || res_valid !== 4'b0000 || sum_out !== 4'h0 || c_out !== 1'b0 || busy !== 1'b0)
      begin errs++; $display("FAIL rmid_outputs got=%b/%b/%h/%b/%b exp=0000/0000/0/0/0", gnt, res_valid, sum_out, c_out, busy); end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req  = (i < 2) ? 4'b1111 : 4'b0000;
      a_in = 16'(($urandom));
      b_in = 16'(($urandom));
      expect_now();
      vecs++; if (gnt !== e_gnt)         begin errs++; $display("FAIL rmid_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      vecs++; if (res_valid !== e_rv)    begin errs++; $display("FAIL rmid_rv cyc=%0d got=%b exp=%b", cyc, res_valid, e_rv); end
      vecs++; if (sum_out !== e_sum)     begin errs++; $display("FAIL rmid_sum cyc=%0d got=%h exp=%h", cyc, sum_out, e_sum); end
      vecs++; if (c_out !== e_c)         begin errs++; $display("FAIL rmid_c cyc=%0d got=%b exp=%b", cyc, c_out, e_c); end
      vecs++; if (busy !== e_busy)       begin errs++; $display("FAIL rmid_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      if (i == 0) begin
        vecs++; if (gnt !== 4'b0001) begin errs++; $display("FAIL rmid_first_gnt got=%b exp=0001", gnt); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req   = 4'($urandom_range(0, 15));
      a_in  = 16'(($urandom));
      b_in  = 16'(($urandom));
      flush = ($urandom_range(0, 9) == 0);
      expect_now();
      vecs++; if (gnt !== e_gnt)         begin errs++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
      vecs++; if (res_valid !== e_rv)    begin errs++; $display("FAIL rnd_rv cyc=%0d got=%b exp=%b", cyc, res_valid, e_rv); end
      vecs++; if (sum_out !== e_sum)     begin errs++; $display("FAIL rnd_sum cyc=%0d got=%h exp=%h", cyc, sum_out, e_sum); end
      vecs++; if (c_out !== e_c)         begin errs++; $display("FAIL rnd_c cyc=%0d got=%b exp=%b", cyc, c_out, e_c); end
      vecs++; if (busy !== e_busy)       begin errs++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      advance();
    end
    flush = 1'b0;
    req   = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning extra pipeline stages after the operand-capture stage (legal 0..3).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 4, one request bit per requester 0..3.
REQ-005 SHALL have port a_in, input, 16, operand A, requester i on bits [4i+3:4i].
REQ-006 SHALL have port b_in, input, 16, operand B, same packing as a_in.
REQ-007 SHALL have port flush, input, 1, synchronous discard of all in-flight operations.
REQ-008 SHALL have port gnt, output, 4, one-hot grant pulse; operands are captured in the cycle gnt[i]=1.
REQ-009 SHALL have port res_valid, output, 4, one-hot result strobe, tagged to the originating requester.
REQ-010 SHALL have port sum_out, output, 4, shared 4-bit sum of the operation flagged by res_valid.
REQ-011 SHALL have port c_out, output, 1, carry of the same operation.
REQ-012 SHALL have port busy, output, 1, high while any operation is in flight.

Function
REQ-013 SHALL drive gnt combinationally from req and the priority pointer: at most one bit set, and gnt=0 when req=0.
REQ-014 SHALL apply round-robin priority: after granting requester i, requester (i+1) mod 4 becomes highest, wrapping 3->0.
REQ-015 SHALL leave the pointer unchanged in cycles with no grant.
REQ-016 SHALL, in the grant cycle, register {c,sum}=a_i+b_i as a 5-bit unsigned sum plus a 2-bit requester tag and a valid bit.
REQ-017 SHALL carry tag and valid through LATENCY further register stages, so res_valid[tag] asserts exactly LATENCY+1 cycles after gnt.
REQ-018 SHALL accept one grant per cycle with no bubbles; results leave in grant order.
REQ-019 SHALL hold sum_out and c_out at their last values while res_valid=0.
REQ-020 SHALL require each requester to hold req and operands stable until its gnt bit; a req dropped before gnt is ignored.
REQ-021 SHALL, when flush=1, clear every stage valid bit on the next edge and suppress gnt in the flush cycle; the pointer is unchanged.
REQ-022 SHALL drive busy as the OR of all stage valid bits.
REQ-023 SHALL wrap overflow into c_out, e.g. 4'hF+4'h1 -> sum 0, c 1.

Reset
REQ-024 SHALL, while RST=0, force gnt=0, res_valid=0, sum_out=0, c_out=0, busy=0 and pointer=0 (requester 0 highest), regardless of CLK.
REQ-025 SHALL discard operations in flight when reset asserts mid-operation; no res_valid for them after release.
REQ-026 SHALL allow the first grant in the first rising edge after RST deasserts.

Configuration
REQ-027 SHALL, with macro ADDER_ARB_FIXED_PRIORITY_EN defined, use fixed priority (requester 0 highest, 3 lowest) and remove the pointer register.
REQ-028 SHALL, with ADDER_ARB_FIXED_PRIORITY_EN undefined, use round-robin per REQ-014; all other behaviour is identical.

Verification
REQ-029 SHALL cover: LATENCY=1, req=0001, a=3, b=4 -> gnt=0001, two cycles later res_valid=0001, sum=7, c=0.
REQ-030 SHALL cover: req=1111 held for 4 cycles, round-robin -> gnt 0001,0010,0100,1000; results in the same order on consecutive cycles.
REQ-031 SHALL cover: a=F, b=1 from requester 2 -> res_valid=0100, sum=0, c=1.
REQ-032 SHALL cover: grants issued, flush=1 one cycle later -> no res_valid for them; busy=0 on the next cycle.
REQ-033 SHALL cover: RST pulsed low with busy=1 -> outputs 0 immediately; no stale res_valid after release; next grant goes to requester 0.
REQ-034 SHALL cover: ADDER_ARB_FIXED_PRIORITY_EN defined, req=1111 held -> gnt=0001 every cycle.
